// File: rtl/multicycle_addsub_if.sv
// Handshake and operand/result bundle for the multi-cycle adder/subtractor.
// The requester drives the master side; the arithmetic unit implements the slave side.
interface multicycle_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, cin, A, B,
        input  busy, done, sum, cout, overflow, zero
    );

    modport slave (
        input  start, sub, cin, A, B,
        output busy, done, sum, cout, overflow, zero
    );
endinterface

// File: rtl/multicycle_addsub.sv
// Shared multi-cycle adder/subtractor: one CHUNK-bit ripple slice per clock,
// carry held between cycles, results published together with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; results hold last completed op
// RUN   | one chunk per edge, cnt_q counts remaining chunks down to 0
module multicycle_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_addsub_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("multicycle_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic             accept, finish;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout, msb_cin;
    logic [WIDTH-1:0] sum_q;
    logic             done_q, cout_q, ovf_q, zero_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands shift right each cycle, so the active chunk always sits in the low bits.
    always_comb begin
        logic c;
        c         = carry_q;
        msb_cin   = carry_q;
        slice_sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) msb_cin = c;
            slice_sum[i] = a_q[i] ^ b_q[i] ^ c;
            c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        slice_cout = c;
        res_d      = (res_q >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (accept) begin
                a_q     <= bus.A;
                b_q     <= bus.B ^ {WIDTH{bus.sub}};
                carry_q <= bus.cin ^ bus.sub;
                cnt_q   <= CNT_W'(NCHUNK - 1);
                res_q   <= '0;
            end else if (state_q == RUN) begin
                a_q     <= a_q >> CHUNK;
                b_q     <= b_q >> CHUNK;
                carry_q <= slice_cout;
                cnt_q   <= cnt_q - CNT_W'(1);
                res_q   <= res_d;
            end
            // Final chunk: publish all flags in the same edge so no partial result is visible.
            if (finish) begin
                sum_q  <= res_d;
                cout_q <= slice_cout;
                ovf_q  <= slice_cout ^ msb_cin;
                zero_q <= (res_d == '0);
            end
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_multicycle_addsub.sv
// Bench for multicycle_addsub: directed handshake/flag cases on an 8/2 instance,
// randomized ops on 8/2, 16/16 and 16/4 instances against an arithmetic model.
module tb_multicycle_addsub;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ov;
        logic        z;
    } res_t;

    multicycle_addsub_if #(.WIDTH(8))  b8 ();
    multicycle_addsub_if #(.WIDTH(16)) b16a ();
    multicycle_addsub_if #(.WIDTH(16)) b16b ();

    multicycle_addsub #(.WIDTH(8),  .CHUNK(2))  dut8   (.clk(clk), .reset(reset), .bus(b8));
    multicycle_addsub #(.WIDTH(16), .CHUNK(16)) dut16a (.clk(clk), .reset(reset), .bus(b16a));
    multicycle_addsub #(.WIDTH(16), .CHUNK(4))  dut16b (.clk(clk), .reset(reset), .bus(b16b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, A+B+cin or A-B-cin, signed range test for overflow.
    function automatic res_t model(input int w, input longint a, input longint b, input bit s, input bit c);
        longint m, sa, sb, cc, u, sr;
        res_t r;
        m  = longint'(1) << w;
        cc = c;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        if (!s) begin
            u      = a + b + cc;
            r.cout = (u >= m);
            sr     = sa + sb + cc;
        end else begin
            u      = a - b - cc;
            r.cout = (u >= 0);
            sr     = sa - sb - cc;
        end
        u     = ((u % m) + m) % m;
        r.sum = 16'(u);
        r.ov  = (sr < -(m / 2)) || (sr >= m / 2);
        r.z   = (u == 0);
        return r;
    endfunction

    task automatic op8(input int a, input int b, input bit s, input bit c,
                       output res_t r, output int lat, output int bsy);
        @(negedge clk);
        b8.A = 8'(a); b8.B = 8'(b); b8.sub = s; b8.cin = c; b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        lat = 0; bsy = 0;
        while (b8.done !== 1'b1 && lat < 40) begin
            if (b8.busy === 1'b1) bsy++;
            @(negedge clk);
            lat++;
        end
        r.sum = 16'(b8.sum); r.cout = b8.cout; r.ov = b8.overflow; r.z = b8.zero;
    endtask

    task automatic op16a(input int a, input int b, input bit s, input bit c,
                         output res_t r, output int lat);
        @(negedge clk);
        b16a.A = 16'(a); b16a.B = 16'(b); b16a.sub = s; b16a.cin = c; b16a.start = 1'b1;
        @(negedge clk);
        b16a.start = 1'b0;
        lat = 0;
        while (b16a.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r.sum = b16a.sum; r.cout = b16a.cout; r.ov = b16a.overflow; r.z = b16a.zero;
    endtask

    task automatic op16b(input int a, input int b, input bit s, input bit c,
                         output res_t r, output int lat);
        @(negedge clk);
        b16b.A = 16'(a); b16b.B = 16'(b); b16b.sub = s; b16b.cin = c; b16b.start = 1'b1;
        @(negedge clk);
        b16b.start = 1'b0;
        lat = 0;
        while (b16b.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r.sum = b16b.sum; r.cout = b16b.cout; r.ov = b16b.overflow; r.z = b16b.zero;
    endtask

    task automatic expect_res(input string tag, input res_t r, input int sum,
                              input bit co, input bit ov, input bit z);
        check({tag, " sum"},  32'(r.sum),  32'(sum));
        check({tag, " cout"}, 32'(r.cout), 32'(co));
        check({tag, " ovf"},  32'(r.ov),   32'(ov));
        check({tag, " zero"}, 32'(r.z),    32'(z));
    endtask

    task automatic verify(input string tag, input int w, input int a, input int b, input bit s,
                          input bit c, input res_t r, input int lat, input int exp_lat);
        res_t m;
        m = model(w, a, b, s, c);
        expect_res(tag, r, int'(m.sum), m.cout, m.ov, m.z);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        res_t r;
        int   lat, bsy, n, a, b;
        bit   s, c, seen;

        b8.start = 0;   b8.sub = 0;   b8.cin = 0;   b8.A = 0;   b8.B = 0;
        b16a.start = 0; b16a.sub = 0; b16a.cin = 0; b16a.A = 0; b16a.B = 0;
        b16b.start = 0; b16b.sub = 0; b16b.cin = 0; b16b.A = 0; b16b.B = 0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst busy", 32'(b8.busy), 0);
        check("rst done", 32'(b8.done), 0);
        check("rst sum",  32'(b8.sum),  0);
        check("rst cout", 32'(b8.cout), 0);
        check("rst ovf",  32'(b8.overflow), 0);
        check("rst zero", 32'(b8.zero), 0);

        op8(100, 27, 0, 0, r, lat, bsy);
        expect_res("t1", r, 127, 0, 0, 0);
        check("t1 latency", 32'(lat), 4);
        check("t1 busy cycles", 32'(bsy), 4);
        check("t1 busy in done cycle", 32'(b8.busy), 0);
        @(negedge clk);
        check("t1 done one cycle", 32'(b8.done), 0);
        check("t1 sum holds", 32'(b8.sum), 127);

        op8(8'h7F, 8'h01, 0, 0, r, lat, bsy);
        expect_res("t2a", r, 8'h80, 0, 1, 0);
        op8(8'hFF, 8'h01, 0, 0, r, lat, bsy);
        expect_res("t2b", r, 8'h00, 1, 0, 1);

        op8(5, 7, 1, 0, r, lat, bsy);
        expect_res("t3a", r, 8'hFE, 0, 0, 0);
        op8(8'h80, 8'h01, 1, 0, r, lat, bsy);
        expect_res("t3b", r, 8'h7F, 1, 1, 0);
        op8(5, 2, 1, 1, r, lat, bsy);
        expect_res("t3c", r, 2, 1, 0, 0);

        // Mid-run start with fresh operands must be ignored.
        @(negedge clk);
        b8.A = 10; b8.B = 20; b8.sub = 0; b8.cin = 0; b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        @(negedge clk);
        b8.A = 200; b8.B = 100; b8.sub = 1; b8.cin = 1; b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        n = 0;
        while (b8.done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check("t4 first done seen", 32'(b8.done), 1);
        check("t4 ignored start sum", 32'(b8.sum), 30);
        check("t4 ignored start cout", 32'(b8.cout), 0);
        check("t4 busy in done cycle", 32'(b8.busy), 0);
        b8.A = 50; b8.B = 60; b8.sub = 0; b8.cin = 0; b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        n = 1;
        while (b8.done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check("t4 back-to-back spacing", 32'(n), 5);
        check("t4 second sum", 32'(b8.sum), 110);

        // Abort two cycles into RUN.
        @(negedge clk);
        b8.A = 3; b8.B = 4; b8.sub = 0; b8.cin = 0; b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5 busy after reset", 32'(b8.busy), 0);
        check("t5 done after reset", 32'(b8.done), 0);
        check("t5 sum after reset",  32'(b8.sum),  0);
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (b8.done === 1'b1 || b8.busy === 1'b1) seen = 1;
        end
        check("t5 aborted op silent", 32'(seen), 0);

        // Reset on the same edge as start wins.
        b8.A = 1; b8.B = 1; b8.start = 1'b1; reset = 1'b1;
        @(negedge clk);
        b8.start = 1'b0; reset = 1'b0;
        check("reset vs start busy", 32'(b8.busy), 0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (b8.done === 1'b1) seen = 1;
        end
        check("reset vs start no done", 32'(seen), 0);

        repeat (400) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            op8(a, b, s, c, r, lat, bsy);
            verify("rnd8", 8, a, b, s, c, r, lat, 4);
        end

        fork
            begin
                res_t ra;
                int   la, aa, ab;
                bit   sa, ca;
                repeat (3000) begin
                    aa = int'($urandom_range(0, 65535));
                    ab = int'($urandom_range(0, 65535));
                    sa = 1'($urandom_range(0, 1));
                    ca = 1'($urandom_range(0, 1));
                    op16a(aa, ab, sa, ca, ra, la);
                    verify("rnd16x16", 16, aa, ab, sa, ca, ra, la, 1);
                end
            end
            begin
                res_t rb;
                int   lb, ba, bb;
                bit   sb, cb;
                repeat (3000) begin
                    ba = int'($urandom_range(0, 65535));
                    bb = int'($urandom_range(0, 65535));
                    sb = 1'($urandom_range(0, 1));
                    cb = 1'($urandom_range(0, 1));
                    op16b(ba, bb, sb, cb, rb, lb);
                    verify("rnd16x4", 16, ba, bb, sb, cb, rb, lb, 4);
                end
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
